instr_enc: RTL and testbench
============================

# instr_enc

Instruction encoder: the inverse of `imm_gen`. It packs an instruction format, register fields, funct3 and a 32-bit immediate into a 32-bit RV32I instruction word, and flags immediates that cannot be represented. It optionally expands the `li` pseudo-instruction into LUI+ADDI. The block feeds the self-checking instruction-stream generator in the bench and the boot-ROM builder, and produces stimulus that round-trips through `imm_gen`. Its request side and its instruction side each use a valid/ready handshake, and the output is registered.

## Interface
- `XLEN`, 32, data/immediate width (from `rv32i_pkg`)
- `ILEN`, 32, instruction width (from `rv32i_pkg`)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid_in`  in  1  request valid
- `req_ready_out`  out  1  request accepted when valid&ready at rising edge
- `req_fmt_in`  in  4  `enc_fmt_e`: I_ALU, I_LD, I_JALR, S, B, LUI, AUIPC, J, LI
- `req_rd_in`, `req_rs1_in`, `req_rs2_in`  in  5 each  register indices
- `req_funct3_in`  in  3  funct3
- `req_imm_in`  in  XLEN  immediate, two's complement
- `instr_valid_out`  out  1  instruction valid
- `instr_ready_in`  in  1  downstream ready
- `instr_out`  out  ILEN  encoded instruction
- `imm_err_out`  out  1  range error, sideband qualified by `instr_valid_out`

## Operation
- Field packing, with opcodes taken from `rv32i_pkg`:
  - I-type: `{imm[11:0], rs1, f3, rd, op}`
  - S-type: `{imm[11:5], rs2, rs1, f3, imm[4:0], op}`
  - B-type: `{imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}`
  - U-type: `{imm[31:12], rd, op}`
  - J-type: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, op}`
- Range checks. A failing check sets `imm_err_out`=1, and the instruction is still emitted with the truncated fields:
  - I and S: -2048..2047
  - B: -4096..4094, and `imm[0]` must be 0
  - J: -2^20..2^20-2, and `imm[0]` must be 0
  - LUI and AUIPC: `imm[11:0]` must be 0
- LI, single-beat case: if the immediate fits in signed 12 bits, emit one `ADDI rd,x0,imm`.
- LI, two-beat case:
  - Compute `lo` = sext(`imm[11:0]`) and `hi` = (`imm`+0x800)[31:12]. The add wraps modulo 2^32.
  - Emit `LUI rd,hi`, then `ADDI rd,rd,lo`.
  - If `lo`==0, emit the LUI only.
  - LI never sets `imm_err_out`.
- An unknown `req_fmt_in` emits a NOP (0x00000013) with `imm_err_out`=1.
- FSM states:
  - IDLE: output empty.
  - LAST: final beat of the current request is on the output.
  - HI: LUI is on the output and the ADDI is pending in a holding register.
- Transitions:
  - IDLE→LAST on a single-beat accept.
  - IDLE→HI on a two-beat accept.
  - HI→LAST when the LUI is taken; the ADDI is loaded in the same edge.
  - LAST→IDLE when the beat is taken and there is no new accept.
  - LAST→LAST or LAST→HI when the beat is taken and a new request is accepted in the same cycle.
- `req_ready_out` = (IDLE) | (LAST & `instr_ready_in`). This is combinational and is 0 while `rst_n`=0.

## Timing
- Latency 1: a request accepted at edge N has its first beat valid from edge N through the next cycle. For LI, the second beat follows one cycle after the first is taken.
- Throughput is 1 request per cycle under continuous `instr_ready_in`. LI two-beat requests take 2 cycles.
- While `instr_valid_out`=1 and `instr_ready_in`=0, `instr_out` and `imm_err_out` hold stable. `instr_valid_out` does not drop.
- Reset values: state=IDLE, `instr_valid_out`=0, `instr_out`=0, `imm_err_out`=0.
- Reset asserted mid-LI discards the pending ADDI. No beat is emitted after reset.
- Request fields are sampled only at the accept edge. They may change freely otherwise.

## Configuration
- `INSTR_ENC_LI_EN` defined: LI expansion, the HI state and the holding register are compiled in.
- `INSTR_ENC_LI_EN` undefined: FMT_LI is treated as an unknown format (NOP, `imm_err_out`=1). The FSM has only IDLE and LAST.

## Structure
- `enc_fmt_e` enum and the NOP constant `INSTR_NOP`=32'h00000013 go in `rv32i_pkg`, next to the existing opcodes.
- Range-check functions `fits_simm(value, bits)` and `is_even` go in `rv32i_pkg`.
- One sub-module, `instr_pack`: combinational format+fields→{instr, err}. Both the first beat and the LI ADDI beat use it.

## Test plan
- I_ALU, rd=2, rs1=1, f3=0, imm=-1 → `instr_out`=0xFFF08113, err=0, valid one cycle after accept.
- Out-of-range and misaligned immediates: S with imm=2048 → err=1; B with imm=3 → err=1.
- B, rs1=1, rs2=0, f3=0, imm=-4 → 0xFE008EE3, err=0.
- LI, rd=5, imm=0x12345678 → beats 0x123452B7 then 0x67828293.
- LI, rd=1, imm=0x7FFFF800 (`hi` wraps) → beats 0x800000B7 then 0x80008093.
- Backpressure, throughput and reset:
  - Hold `instr_ready_in`=0 for 3 cycles mid-LI → outputs stable and `req_ready_out`=0.
  - Release → 4 back-to-back I-type requests drain at 1 per cycle.
  - `rst_n`=0 in state HI → no ADDI appears and `instr_valid_out`=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I widths, opcodes, encoder formats and immediate range helpers
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h00000013;
  typedef enum logic [3:0] {
    FMT_I_ALU, FMT_I_LD, FMT_I_JALR, FMT_S, FMT_B, FMT_LUI, FMT_AUIPC, FMT_J, FMT_LI
  } enc_fmt_e;
  function automatic logic fits_simm(input logic [XLEN-1:0] value, input int bits);
    logic [XLEN-1:0] msbs;
    msbs = XLEN'($signed(value) >>> (bits - 1));
    return msbs == '0 || msbs == '1;
  endfunction
  function automatic logic is_even(input logic [XLEN-1:0] value);
    return !value[0];
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: packs format + fields into one RV32I word and flags unrepresentable immediates
module instr_pack
  import rv32i_pkg::*;
(
  input  logic [3:0]      fmt_i,
  input  logic [4:0]      rd_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [2:0]      f3_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [ILEN-1:0] instr_o,
  output logic            err_o
);
  always_comb begin
    instr_o = INSTR_NOP;
    err_o   = 1'b1;
    case (fmt_i)
      FMT_I_ALU, FMT_I_LD, FMT_I_JALR: begin
        instr_o = {imm_i[11:0], rs1_i, f3_i, rd_i,
                   fmt_i == FMT_I_ALU ? OP_IMM : fmt_i == FMT_I_LD ? OP_LOAD : OP_JALR};
        err_o   = !fits_simm(imm_i, 12);
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], OP_STORE};
        err_o   = !fits_simm(imm_i, 12);
      end
      FMT_B: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i, imm_i[4:1], imm_i[11], OP_BRANCH};
        err_o   = !(fits_simm(imm_i, 13) && is_even(imm_i));
      end
      FMT_LUI, FMT_AUIPC: begin
        instr_o = {imm_i[31:12], rd_i, fmt_i == FMT_LUI ? OP_LUI : OP_AUIPC};
        err_o   = imm_i[11:0] != '0;
      end
      FMT_J: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        err_o   = !(fits_simm(imm_i, 21) && is_even(imm_i));
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/instr_enc.sv
// instr_enc: registered valid/ready RV32I instruction encoder; `INSTR_ENC_LI_EN enables li -> LUI+ADDI expansion
module instr_enc
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [3:0]      req_fmt_in,
  input  logic [4:0]      req_rd_in,
  input  logic [4:0]      req_rs1_in,
  input  logic [4:0]      req_rs2_in,
  input  logic [2:0]      req_funct3_in,
  input  logic [XLEN-1:0] req_imm_in,
  output logic            instr_valid_out,
  input  logic            instr_ready_in,
  output logic [ILEN-1:0] instr_out,
  output logic            imm_err_out
);
`ifdef INSTR_ENC_LI_EN
  typedef enum logic [1:0] {IDLE, LAST, HI} state_e;
`else
  typedef enum logic [0:0] {IDLE, LAST} state_e;
`endif
  state_e state_q, state_d;
  logic [ILEN-1:0] instr_q, instr_d, beat;
  logic err_q, err_d, beat_err, accept, take, two_beat;
  logic [3:0] p_fmt;
  logic [4:0] p_rd, p_rs1;
  logic [2:0] p_f3;
  logic [XLEN-1:0] p_imm;
`ifdef INSTR_ENC_LI_EN
  logic [4:0] rd_q;
  logic [11:0] lo_q;
  logic li, fits, hi_st;
  // In HI the packer is free (no accept possible), so it builds the pending ADDI from the held fields
  assign li       = req_fmt_in == FMT_LI;
  assign fits     = fits_simm(req_imm_in, 12);
  assign hi_st    = state_q == HI;
  assign two_beat = li && !fits && req_imm_in[11:0] != '0;
  assign p_fmt    = hi_st || (li && fits) ? FMT_I_ALU : li ? FMT_LUI : req_fmt_in;
  assign p_rd     = hi_st ? rd_q : req_rd_in;
  assign p_rs1    = hi_st ? rd_q : li ? 5'd0 : req_rs1_in;
  assign p_f3     = hi_st || li ? 3'd0 : req_funct3_in;
  assign p_imm    = hi_st ? {{20{lo_q[11]}}, lo_q} :
                    li && !fits ? {req_imm_in + 32'h800} & 32'hffff_f000 : req_imm_in;
`else
  assign two_beat = 1'b0;
  assign p_fmt    = req_fmt_in;
  assign p_rd     = req_rd_in;
  assign p_rs1    = req_rs1_in;
  assign p_f3     = req_funct3_in;
  assign p_imm    = req_imm_in;
`endif
  instr_pack u_pack (
    .fmt_i  (p_fmt),
    .rd_i   (p_rd),
    .rs1_i  (p_rs1),
    .rs2_i  (req_rs2_in),
    .f3_i   (p_f3),
    .imm_i  (p_imm),
    .instr_o(beat),
    .err_o  (beat_err)
  );
  assign req_ready_out   = rst_n && (state_q == IDLE || (state_q == LAST && instr_ready_in));
  assign accept          = req_valid_in && req_ready_out;
  assign instr_valid_out = state_q != IDLE;
  assign take            = instr_valid_out && instr_ready_in;
  assign instr_out       = instr_q;
  assign imm_err_out     = err_q;
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    if (accept) begin
`ifdef INSTR_ENC_LI_EN
      state_d = two_beat ? HI : LAST;
`else
      state_d = LAST;
`endif
      instr_d = beat;
      err_d   = beat_err;
    end else if (take) begin
      state_d = state_q == LAST ? IDLE : LAST;
      instr_d = beat;
      err_d   = beat_err;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      err_q   <= 1'b0;
`ifdef INSTR_ENC_LI_EN
      rd_q    <= '0;
      lo_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
`ifdef INSTR_ENC_LI_EN
      if (accept) begin
        rd_q <= req_rd_in;
        lo_q <= req_imm_in[11:0];
      end
`endif
    end
  end
endmodule

// File: tb/tb_instr_enc.sv
// tb_instr_enc: table-driven vectors plus LI, backpressure, throughput and reset sequences
module tb_instr_enc;
  import rv32i_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid_in = 1'b0, req_ready_out, instr_valid_out, instr_ready_in = 1'b1, imm_err_out;
  logic [3:0] req_fmt_in = '0;
  logic [4:0] req_rd_in = '0, req_rs1_in = '0, req_rs2_in = '0;
  logic [2:0] req_funct3_in = '0;
  logic [31:0] req_imm_in = '0, instr_out;
  int total = 0, bad = 0;

  typedef struct {
    logic [3:0] fmt; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [31:0] imm;
    logic [31:0] instr; logic err;
  } vec_t;
  vec_t vq[$];

  instr_enc dut (
    .clk(clk), .rst_n(rst_n), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_fmt_in(req_fmt_in), .req_rd_in(req_rd_in), .req_rs1_in(req_rs1_in),
    .req_rs2_in(req_rs2_in), .req_funct3_in(req_funct3_in), .req_imm_in(req_imm_in),
    .instr_valid_out(instr_valid_out), .instr_ready_in(instr_ready_in),
    .instr_out(instr_out), .imm_err_out(imm_err_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    req_valid_in = 1'b1; req_fmt_in = fmt; req_rd_in = rd; req_rs1_in = rs1;
    req_rs2_in = rs2; req_funct3_in = f3; req_imm_in = imm;
  endtask

  function automatic vec_t mk(input logic [3:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                              input logic [31:0] instr, input logic err);
    vec_t v;
    v.fmt = fmt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.imm = imm;
    v.instr = instr; v.err = err;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vq.push_back(mk(FMT_I_ALU,  2, 1, 0, 0, 32'hffffffff, 32'hfff08113, 0));
    vq.push_back(mk(FMT_I_ALU,  0, 0, 0, 0, 32'hfffff7ff, 32'h7ff00013, 1));
    vq.push_back(mk(FMT_I_LD,   6, 2, 0, 2, 32'd8,        32'h00812303, 0));
    vq.push_back(mk(FMT_I_JALR, 1, 5, 0, 0, 32'd2047,     32'h7ff280e7, 0));
    vq.push_back(mk(FMT_S,      0, 2, 3, 2, 32'd2048,     32'h80312023, 1));
    vq.push_back(mk(FMT_S,      0, 2, 3, 2, 32'hfffff800, 32'h80312023, 0));
    vq.push_back(mk(FMT_B,      0, 0, 0, 0, 32'd3,        32'h00000163, 1));
    vq.push_back(mk(FMT_B,      0, 1, 0, 0, 32'hfffffffc, 32'hfe008ee3, 0));
    vq.push_back(mk(FMT_B,      0, 0, 0, 0, 32'd4094,     32'h7e000fe3, 0));
    vq.push_back(mk(FMT_B,      0, 0, 0, 0, 32'd4096,     32'h80000063, 1));
    vq.push_back(mk(FMT_J,      1, 0, 0, 0, 32'hfff00000, 32'h800000ef, 0));
    vq.push_back(mk(FMT_J,      1, 0, 0, 0, 32'h00100000, 32'h800000ef, 1));
    vq.push_back(mk(FMT_J,      0, 0, 0, 0, 32'd2,        32'h0020006f, 0));
    vq.push_back(mk(FMT_LUI,    3, 0, 0, 0, 32'h12345000, 32'h123451b7, 0));
    vq.push_back(mk(FMT_LUI,    3, 0, 0, 0, 32'h12345001, 32'h123451b7, 1));
    vq.push_back(mk(FMT_AUIPC,  4, 0, 0, 0, 32'hfffff000, 32'hfffff217, 0));
    vq.push_back(mk(4'hf,       7, 7, 7, 7, 32'h1,        32'h00000013, 1));
`ifdef INSTR_ENC_LI_EN
    vq.push_back(mk(FMT_LI,     7, 0, 0, 0, 32'hfffffffb, 32'hffb00393, 0));
`else
    vq.push_back(mk(FMT_LI,     7, 0, 0, 0, 32'hfffffffb, 32'h00000013, 1));
`endif
    repeat (3) step();
    chk("rst_valid", {31'd0, instr_valid_out}, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_err", {31'd0, imm_err_out}, 0);
    chk("rst_ready", {31'd0, req_ready_out}, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", {31'd0, req_ready_out}, 1);
    foreach (vq[i]) begin
      drive(vq[i].fmt, vq[i].rd, vq[i].rs1, vq[i].rs2, vq[i].f3, vq[i].imm);
      step();
      req_valid_in = 1'b0;
      chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid_out}, 1);
      chk($sformatf("vec%0d_instr", i), instr_out, vq[i].instr);
      chk($sformatf("vec%0d_err", i), {31'd0, imm_err_out}, {31'd0, vq[i].err});
    end
    step();
    chk("drain_idle", {31'd0, instr_valid_out}, 0);
`ifdef INSTR_ENC_LI_EN
    instr_ready_in = 1'b0;
    drive(FMT_LI, 5, 0, 0, 0, 32'h12345678);
    step();
    req_valid_in = 1'b0;
    chk("li_lui", instr_out, 32'h123452b7);
    chk("li_lui_valid", {31'd0, instr_valid_out}, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_instr", instr_out, 32'h123452b7);
      chk("bp_valid", {31'd0, instr_valid_out}, 1);
      chk("bp_ready", {31'd0, req_ready_out}, 0);
    end
    instr_ready_in = 1'b1;
    step();
    chk("li_addi", instr_out, 32'h67828293);
    chk("li_addi_err", {31'd0, imm_err_out}, 0);
    chk("li_addi_ready", {31'd0, req_ready_out}, 1);
    for (int k = 1; k <= 4; k++) begin
      drive(FMT_I_ALU, 5'(k), 0, 0, 0, 32'(k));
      step();
      chk("b2b_instr", instr_out, (32'(k) << 20) | (32'(k) << 7) | 32'h13);
      chk("b2b_valid", {31'd0, instr_valid_out}, 1);
    end
    req_valid_in = 1'b0;
    step();
    chk("b2b_drain", {31'd0, instr_valid_out}, 0);
    drive(FMT_LI, 1, 0, 0, 0, 32'h7ffff800);
    step();
    req_valid_in = 1'b0;
    chk("wrap_lui", instr_out, 32'h800000b7);
    chk("wrap_lui_err", {31'd0, imm_err_out}, 0);
    step();
    chk("wrap_addi", instr_out, 32'h80008093);
    step();
    chk("wrap_done", {31'd0, instr_valid_out}, 0);
    drive(FMT_LI, 2, 0, 0, 0, 32'h00005000);
    step();
    req_valid_in = 1'b0;
    chk("lo0_lui", instr_out, 32'h00005137);
    step();
    chk("lo0_single", {31'd0, instr_valid_out}, 0);
    instr_ready_in = 1'b0;
    drive(FMT_LI, 5, 0, 0, 0, 32'h12345678);
    step();
    req_valid_in = 1'b0;
    chk("rsthi_lui", instr_out, 32'h123452b7);
    rst_n = 1'b0;
    instr_ready_in = 1'b1;
    step();
    chk("rsthi_valid", {31'd0, instr_valid_out}, 0);
    chk("rsthi_instr", instr_out, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rsthi_no_addi", {31'd0, instr_valid_out}, 0);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
